// File: rtl/coil_chopper.sv
// Constant-off-time H-bridge chopper with dead time and latched overcurrent; all outputs registered (1 edge latency).
// COIL_SLOW_DECAY_EN: off time uses slow decay (both low switches on); default build uses fast decay (all off).
module coil_chopper #(
    parameter int CURRENT_BITS = 13,
    parameter int TIMER_BITS   = 8,
    parameter int DEADTIME     = 4,
    parameter int BLANK_TIME   = 8,
    parameter int OFF_TIME     = 32,
    parameter int OC_LIMIT     = 4000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    direction,
    input  logic [CURRENT_BITS-1:0] target_current,
    input  logic [CURRENT_BITS-1:0] current,
    output logic                    s_l0,
    output logic                    s_h0,
    output logic                    s_l1,
    output logic                    s_h1,
    output logic                    drive_active,
    output logic                    fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAD  = 3'd1,
        BLANK = 3'd2,
        DRIVE = 3'd3,
        OFFT  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [CURRENT_BITS-1:0] OC_LIM = CURRENT_BITS'(OC_LIMIT);

`ifdef COIL_SLOW_DECAY_EN
    localparam logic SLOW_DECAY = 1'b1;
`else
    localparam logic SLOW_DECAY = 1'b0;
`endif

    state_t                state, state_n;
    state_t                dead_next, dead_next_n;
    logic                  dir_q, dir_n;
    logic [TIMER_BITS-1:0] timer, timer_n;
    logic                  drv_n, off_n;

    // Timer holds cycles remaining minus one, so a phase of length L exits after L cycles.
    function automatic logic [TIMER_BITS-1:0] phase_load(input state_t s);
        int len;
        case (s)
            DEAD:    len = DEADTIME;
            BLANK:   len = BLANK_TIME;
            OFFT:    len = OFF_TIME;
            default: len = 0;
        endcase
        return (len > 0) ? TIMER_BITS'(len - 1) : '0;
    endfunction

    always_comb begin
        state_n     = state;
        dead_next_n = dead_next;
        dir_n       = dir_q;
        timer_n     = (timer == '0) ? timer : timer - TIMER_BITS'(1);
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_n     = DEAD;
                    dir_n       = direction;
                    dead_next_n = BLANK;
                end
                DEAD: begin
                    if (timer == '0) state_n = dead_next;
                end
                BLANK, DRIVE: begin
                    if (current >= OC_LIM) begin
                        state_n = FAULT;
                    end else if (direction != dir_q) begin
                        state_n     = DEAD;
                        dir_n       = direction;
                        dead_next_n = BLANK;
                    end else if (state == DRIVE || timer == '0) begin
                        // The last blank cycle doubles as the first DRIVE compare, so a pulse is never shorter than the blank.
                        if (current >= target_current) begin
                            state_n     = DEAD;
                            dead_next_n = OFFT;
                        end else begin
                            state_n = DRIVE;
                        end
                    end
                end
                OFFT: begin
                    if (timer == '0) begin
                        state_n     = DEAD;
                        dir_n       = direction;
                        dead_next_n = BLANK;
                    end
                end
                FAULT:   state_n = FAULT;
                default: state_n = IDLE;
            endcase
        end
        if (state_n != state) timer_n = phase_load(state_n);
    end

    assign drv_n = (state_n == BLANK) || (state_n == DRIVE);
    assign off_n = (state_n == OFFT) && SLOW_DECAY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dead_next    <= BLANK;
            dir_q        <= 1'b0;
            timer        <= '0;
            s_l0         <= 1'b1;
            s_h0         <= 1'b1;
            s_l1         <= 1'b1;
            s_h1         <= 1'b1;
            drive_active <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            dead_next    <= dead_next_n;
            dir_q        <= dir_n;
            timer        <= timer_n;
            s_l0         <= !((drv_n && !dir_n) || off_n);
            s_h0         <= !(drv_n && dir_n);
            s_l1         <= !((drv_n && dir_n) || off_n);
            s_h1         <= !(drv_n && !dir_n);
            drive_active <= drv_n;
            fault        <= (state_n == FAULT);
        end
    end

endmodule

// File: tb/tb_coil_chopper.sv
// Bench for coil_chopper: phase/age reference model checked every cycle, plus hand-computed timing points.
// Coil model: current +1 per cycle while a drive pattern is on the pins, otherwise 0.
module tb_coil_chopper;

    localparam int CB  = 13;
    localparam int DT  = 4;
    localparam int BT  = 8;
    localparam int OT  = 32;
    localparam int OCL = 100;

    localparam int P_IDLE  = 0;
    localparam int P_DEAD  = 1;
    localparam int P_BLANK = 2;
    localparam int P_DRIVE = 3;
    localparam int P_OFF   = 4;
    localparam int P_FAULT = 5;

    logic          clk = 1'b0;
    logic          reset, enable, direction;
    logic [CB-1:0] target_current, current;
    logic          s_l0, s_h0, s_l1, s_h1, drive_active, fault;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    int   m_ph, m_age, m_after;
    logic m_dir;

    always #5 clk = ~clk;

    coil_chopper #(
        .CURRENT_BITS(CB), .TIMER_BITS(8), .DEADTIME(DT),
        .BLANK_TIME(BT), .OFF_TIME(OT), .OC_LIMIT(OCL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .direction(direction),
        .target_current(target_current), .current(current),
        .s_l0(s_l0), .s_h0(s_h0), .s_l1(s_l1), .s_h1(s_h1),
        .drive_active(drive_active), .fault(fault)
    );

    // Pin order {s_l0, s_h0, s_l1, s_h1}
    function automatic logic [3:0] pins_of(input int ph, input logic d);
        if (ph == P_BLANK || ph == P_DRIVE) return d ? 4'b1001 : 4'b0110;
`ifdef COIL_SLOW_DECAY_EN
        if (ph == P_OFF) return 4'b0101;
`endif
        return 4'b1111;
    endfunction

    function automatic logic [3:0] pins_now();
        return {s_l0, s_h0, s_l1, s_h1};
    endfunction

    function automatic logic driving();
        return (pins_now() == 4'b0110) || (pins_now() == 4'b1001);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0d: actual=%h required=%h", name, t, got, exp);
        end
    endtask

    // Phases are tracked as (phase, cycles spent so far); a phase of length L ends once it has lasted L cycles.
    task automatic model_step(input logic r, input logic e, input logic d,
                              input logic [CB-1:0] tg, input logic [CB-1:0] cu);
        int nph;
        if (r) begin
            m_ph = P_IDLE; m_age = 0; m_dir = 1'b0; m_after = P_BLANK;
            return;
        end
        nph = m_ph;
        if (!e) begin
            nph = P_IDLE;
        end else if (m_ph == P_IDLE) begin
            nph = P_DEAD; m_dir = d; m_after = P_BLANK;
        end else if (m_ph == P_DEAD) begin
            if (m_age >= DT) nph = m_after;
        end else if (m_ph == P_BLANK || m_ph == P_DRIVE) begin
            if (int'(cu) >= OCL) nph = P_FAULT;
            else if (d != m_dir) begin
                nph = P_DEAD; m_dir = d; m_after = P_BLANK;
            end else if (m_ph == P_DRIVE || m_age >= BT) begin
                if (cu >= tg) begin
                    nph = P_DEAD; m_after = P_OFF;
                end else nph = P_DRIVE;
            end
        end else if (m_ph == P_OFF) begin
            if (m_age >= OT) begin
                nph = P_DEAD; m_dir = d; m_after = P_BLANK;
            end
        end
        if (nph != m_ph) m_age = 1;
        else m_age++;
        m_ph = nph;
    endtask

    task automatic tick();
        logic r, e, d;
        logic [CB-1:0] tg, cu;
        logic [5:0] exp;
        r = reset; e = enable; d = direction; tg = target_current; cu = current;
        @(posedge clk);
        model_step(r, e, d, tg, cu);
        #1;
        t++;
        exp = {pins_of(m_ph, m_dir), (m_ph == P_BLANK || m_ph == P_DRIVE), (m_ph == P_FAULT)};
        check("model", {2'b00, pins_now(), drive_active, fault}, {2'b00, exp});
        check("leg", {6'd0, !s_l0 && !s_h0, !s_l1 && !s_h1}, 8'd0);
        if (driving()) current = current + 1'b1;
        else current = '0;
    endtask

    initial begin
        int rises[$];
        int falls[$];
        int plens[$];
        int run, first_fault;
        logic prev;
        logic [3:0] rev[6];
        int exp_r[3];
        int exp_f[3];
        exp_r = '{5, 65, 125};
        exp_f = '{25, 85, 145};

        m_ph = P_IDLE; m_age = 0; m_dir = 1'b0; m_after = P_BLANK;
        reset = 1'b1; enable = 1'b0; direction = 1'b0;
        target_current = '0; current = '0;

        // Reset, with enable low then high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_en0", {2'b00, pins_now(), drive_active, fault}, 8'b00111100);
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_en1", {2'b00, pins_now(), drive_active, fault}, 8'b00111100);
        end
        reset = 1'b0; enable = 1'b0;
        tick();

        // Regulation: target 20, three periods
        target_current = 13'd20; direction = 1'b0; enable = 1'b1; t = 0; prev = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (driving() && !prev) rises.push_back(t);
            if (!driving() && prev) falls.push_back(t);
            prev = driving();
        end
        check("reg_nrise", 8'(rises.size()), 8'd3);
        check("reg_nfall", 8'(falls.size()), 8'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rises.size()) check("reg_rise", 8'(rises[i]), 8'(exp_r[i]));
            if (i < falls.size()) check("reg_fall", 8'(falls[i]), 8'(exp_f[i]));
        end

        // Reversal mid-DRIVE
        enable = 1'b0;
        tick();
        enable = 1'b1; direction = 1'b0; t = 0;
        for (int i = 0; i < 16; i++) tick();
        check("rev_pre", {4'd0, pins_now()}, 8'h06);
        direction = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            rev[i] = pins_now();
        end
        for (int i = 1; i <= 4; i++) check("rev_dead", {4'd0, rev[i]}, 8'h0f);
        check("rev_neg", {4'd0, rev[5]}, 8'h09);
        for (int i = 0; i < 30; i++) tick();

        // Blanking: target below the current reached during the blank
        enable = 1'b0;
        tick();
        enable = 1'b1; direction = 1'b1; target_current = 13'd3; t = 0; prev = 1'b0; run = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (driving()) run++;
            else if (prev) begin
                plens.push_back(run);
                run = 0;
            end
            prev = driving();
        end
        check("blank_npulse", 8'(plens.size()), 8'd2);
        foreach (plens[i]) check("blank_len", 8'(plens[i]), 8'(BT));

        // Overcurrent
        enable = 1'b0;
        tick();
        enable = 1'b1; direction = 1'b0; target_current = 13'd200; t = 0; first_fault = -1;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (fault && first_fault < 0) first_fault = t;
        end
        check("oc_time", 8'(first_fault), 8'd105);
        check("oc_hold", {2'b00, pins_now(), drive_active, fault}, 8'b00111101);
        enable = 1'b0;
        tick();
        check("oc_clear", {2'b00, pins_now(), drive_active, fault}, 8'b00111100);

        // Reset mid-DRIVE, then off-time decay pattern
        enable = 1'b1; target_current = 13'd200; t = 0;
        for (int i = 0; i < 20; i++) tick();
        check("mid_drive", {7'd0, drive_active}, 8'd1);
        reset = 1'b1;
        tick();
        check("mid_reset", {2'b00, pins_now(), drive_active, fault}, 8'b00111100);
        reset = 1'b0; target_current = 13'd5; t = 0;
        for (int i = 0; i < 20; i++) tick();
`ifdef COIL_SLOW_DECAY_EN
        check("offt_pins", {4'd0, pins_now()}, 8'h05);
`else
        check("offt_pins", {4'd0, pins_now()}, 8'h0f);
`endif
        for (int i = 0; i < 40; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
